// File: rtl/test_monitor.sv
// test_monitor
//   Self-test result checker. On every temp_trg pulse the CPU result on
//   temp_out is compared (under MASK) against the next entry of the EXPECTED
//   sequence. A pass, fail or timeout verdict latches until restart or rst.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   restart       synchronous re-arm (same effect as rst on checker state)
//   temp_out      CPU result value
//   temp_trg      one-cycle result-valid strobe
//   busy          checker running
//   done          verdict reached
//   led_g, led_r  pass / fail-or-timeout indicators
//   timeout       failure was caused by the idle timeout
//   step          index of next expected step, frozen at the verdict
//   fail_val      temp_out sampled at the mismatch (0 on timeout)
module test_monitor #(
    parameter int                       WIDTH    = 32,
    parameter int                       DEPTH    = 1,
    parameter int                       IDX_BITS = 1,
    parameter logic [DEPTH*WIDTH-1:0]   EXPECTED = 32'h00004038,
    parameter logic [WIDTH-1:0]         MASK     = '1,
    parameter int                       TO_BITS  = 24,
    parameter int                       TIMEOUT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                restart,
    input  logic [WIDTH-1:0]    temp_out,
    input  logic                temp_trg,
    output logic                busy,
    output logic                done,
    output logic                led_g,
    output logic                led_r,
    output logic                timeout,
    output logic [IDX_BITS-1:0] step,
    output logic [WIDTH-1:0]    fail_val
);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

    localparam int                  NSLOT   = 1 << IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST    = IDX_BITS'(DEPTH - 1);
    localparam logic                TO_EN   = (TIMEOUT != 0);
    localparam logic [TO_BITS-1:0]  TO_LAST = TO_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TO_BITS-1:0]     cnt_q, cnt_d;
    logic [IDX_BITS-1:0]    step_d;
    logic [WIDTH-1:0]       fail_val_d;
    logic                   timeout_d;

    // One comparator per sequence slot; the hit vector is padded to the full
    // index range so that step can select it without going out of bounds.
    logic [NSLOT-1:0] hit;
    for (genvar i = 0; i < NSLOT; i++) begin : g_cmp
        if (i < DEPTH) begin : g_live
            assign hit[i] = ((temp_out ^ EXPECTED[i*WIDTH +: WIDTH]) & MASK) == '0;
        end else begin : g_pad
            assign hit[i] = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step;
        fail_val_d = fail_val;
        timeout_d  = timeout;
        if (restart) begin
            // restart beats a coincident trigger: the trigger is dropped
            state_d    = S_RUN;
            cnt_d      = '0;
            step_d     = '0;
            fail_val_d = '0;
            timeout_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            if (temp_trg) begin
                // a trigger wins over a timeout expiring in the same cycle
                if (hit[step]) begin
                    cnt_d = '0;
                    if (step == LAST) state_d = S_PASS;
                    else              step_d  = step + IDX_BITS'(1);
                end else begin
                    state_d    = S_FAIL;
                    fail_val_d = temp_out;
                    timeout_d  = 1'b0;
                end
            end else if (TO_EN) begin
                if (cnt_q == TO_LAST) begin
                    state_d    = S_FAIL;
                    fail_val_d = '0;
                    timeout_d  = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TO_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs registered from the next state so a trigger at edge N is
    // visible in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            led_g    <= 1'b0;
            led_r    <= 1'b0;
            timeout  <= 1'b0;
            step     <= '0;
            fail_val <= '0;
        end else begin
            busy     <= (state_d == S_RUN);
            done     <= (state_d == S_PASS) || (state_d == S_FAIL);
            led_g    <= (state_d == S_PASS);
            led_r    <= (state_d == S_FAIL);
            timeout  <= timeout_d;
            step     <= step_d;
            fail_val <= fail_val_d;
        end
    end

endmodule

// File: tb/tb_test_monitor.sv
module tb_test_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        temp_trg = 1'b0;
    logic [31:0] temp_out = '0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // per-instance outputs
    logic        b0, d0, g0, r0, t0;  logic [0:0] s0;  logic [31:0] f0;
    logic        b1, d1, g1, r1, t1;  logic [1:0] s1;  logic [31:0] f1;
    logic        b2, d2, g2, r2, t2;  logic [1:0] s2;  logic [31:0] f2;
    logic        b3, d3, g3, r3, t3;  logic [0:0] s3;  logic [31:0] f3;

    // u0: legacy defaults
    test_monitor u0 (
        .clk(clk), .rst(rst), .restart(restart), .temp_out(temp_out), .temp_trg(temp_trg),
        .busy(b0), .done(d0), .led_g(g0), .led_r(r0), .timeout(t0), .step(s0), .fail_val(f0));

    // u1: three-step sequence 1,2,3
    test_monitor #(.DEPTH(3), .IDX_BITS(2), .EXPECTED(96'h00000003_00000002_00000001)) u1 (
        .clk(clk), .rst(rst), .restart(restart), .temp_out(temp_out), .temp_trg(temp_trg),
        .busy(b1), .done(d1), .led_g(g1), .led_r(r1), .timeout(t1), .step(s1), .fail_val(f1));

    // u2: same sequence with a 5-cycle idle timeout
    test_monitor #(.DEPTH(3), .IDX_BITS(2), .EXPECTED(96'h00000003_00000002_00000001),
                   .TIMEOUT(5)) u2 (
        .clk(clk), .rst(rst), .restart(restart), .temp_out(temp_out), .temp_trg(temp_trg),
        .busy(b2), .done(d2), .led_g(g2), .led_r(r2), .timeout(t2), .step(s2), .fail_val(f2));

    // u3: low half-word mask
    test_monitor #(.MASK(32'h0000FFFF)) u3 (
        .clk(clk), .rst(rst), .restart(restart), .temp_out(temp_out), .temp_trg(temp_trg),
        .busy(b3), .done(d3), .led_g(g3), .led_r(r3), .timeout(t3), .step(s3), .fail_val(f3));

    typedef struct {
        int          dut;
        int          due;
        string       tag;
        logic        busy, done, g, r, to;
        logic [31:0] st, fv;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // drive one cycle of stimulus; d>=0 queues the outputs expected after the edge
    task automatic tick(input logic r, input logic rs, input logic trg, input logic [31:0] v,
                        input int d, input string tag,
                        input logic b, input logic dn, input logic g, input logic rr,
                        input logic to, input logic [31:0] st, input logic [31:0] fv);
        exp_t e;
        rst = r; restart = rs; temp_trg = trg; temp_out = v;
        if (d >= 0) begin
            e.dut = d; e.due = cyc + 1; e.tag = tag;
            e.busy = b; e.done = dn; e.g = g; e.r = rr; e.to = to; e.st = st; e.fv = fv;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    // scoreboard: compare on the falling edge once the entry's edge has passed
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic        ob, od, og, orr, ot;
            logic [31:0] os, of;
            e = q.pop_front();
            case (e.dut)
                0:       begin ob=b0; od=d0; og=g0; orr=r0; ot=t0; os=32'(s0); of=f0; end
                1:       begin ob=b1; od=d1; og=g1; orr=r1; ot=t1; os=32'(s1); of=f1; end
                2:       begin ob=b2; od=d2; og=g2; orr=r2; ot=t2; os=32'(s2); of=f2; end
                default: begin ob=b3; od=d3; og=g3; orr=r3; ot=t3; os=32'(s3); of=f3; end
            endcase
            chk({e.tag, ".busy"},     32'(ob),  32'(e.busy));
            chk({e.tag, ".done"},     32'(od),  32'(e.done));
            chk({e.tag, ".led_g"},    32'(og),  32'(e.g));
            chk({e.tag, ".led_r"},    32'(orr), 32'(e.r));
            chk({e.tag, ".timeout"},  32'(ot),  32'(e.to));
            chk({e.tag, ".step"},     os,       e.st);
            chk({e.tag, ".fail_val"}, of,       e.fv);
        end
    end

    initial begin
        // legacy single-value checker, verdict latches
        tick(1,0,0,0,            0,"leg_rst", 1,0,0,0,0,0,0);
        tick(0,0,1,32'h00004038, 0,"leg_pass",0,1,1,0,0,0,0);
        tick(0,0,1,32'h0,        0,"leg_hold",0,1,1,0,0,0,0);

        // three-step pass with back-to-back triggers
        tick(1,0,0,0, 1,"seq_rst", 1,0,0,0,0,0,0);
        tick(0,0,1,1, 1,"seq_s1",  1,0,0,0,0,1,0);
        tick(0,0,1,2, 1,"seq_s2",  1,0,0,0,0,2,0);
        tick(0,0,1,3, 1,"seq_pass",0,1,1,0,0,2,0);

        // mismatch at step 1, later trigger ignored
        tick(1,0,0,0, 1,"mis_rst", 1,0,0,0,0,0,0);
        tick(0,0,1,1, 1,"mis_s1",  1,0,0,0,0,1,0);
        tick(0,0,1,7, 1,"mis_fail",0,1,0,1,0,1,7);
        tick(0,0,1,2, 1,"mis_hold",0,1,0,1,0,1,7);

        // restart with a coincident trigger: trigger dropped
        tick(0,1,1,1, 1,"rstrt",   1,0,0,0,0,0,0);
        tick(0,0,1,1, 1,"rstrt_s1",1,0,0,0,0,1,0);
        // rst mid-sequence, also overriding restart
        tick(1,1,1,2, 1,"midrst",  1,0,0,0,0,0,0);

        // timeout with no triggers: FAIL exactly 5 cycles after the arming edge
        tick(1,0,0,0, 2,"to_rst",1,0,0,0,0,0,0);
        for (int k = 0; k < 4; k++) tick(0,0,0,0, 2,"to_idle",1,0,0,0,0,0,0);
        tick(0,0,0,0, 2,"to_fire",0,1,0,1,1,0,0);
        tick(0,0,1,1, 2,"to_hold",0,1,0,1,1,0,0);

        // trigger in the cycle the counter reaches TIMEOUT-1 wins and clears it
        tick(1,0,0,0, 2,"race_rst",1,0,0,0,0,0,0);
        for (int k = 0; k < 4; k++) tick(0,0,0,0, 2,"race_idle",1,0,0,0,0,0,0);
        tick(0,0,1,1, 2,"race_trg",1,0,0,0,0,1,0);
        for (int k = 0; k < 4; k++) tick(0,0,0,0, 2,"race_idle2",1,0,0,0,0,1,0);
        tick(0,0,0,0, 2,"race_fire",0,1,0,1,1,1,0);

        // masked compare
        tick(1,0,0,0,            3,"msk_rst", 1,0,0,0,0,0,0);
        tick(0,0,1,32'hABCD4038, 3,"msk_pass",0,1,1,0,0,0,0);
        tick(1,0,0,0,            3,"msk_rst2",1,0,0,0,0,0,0);
        tick(0,0,1,32'hABCD4039, 3,"msk_fail",0,1,0,1,0,0,32'hABCD4039);

        tick(0,0,0,0,-1,"",0,0,0,0,0,0,0);
        tick(0,0,0,0,-1,"",0,0,0,0,0,0,0);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/test_monitor.md
# test_monitor

Parametrised self-test result checker for the ECO32 top level. It samples the CPU's temporary result bus on each trigger pulse and compares the result against a sequence of up to DEPTH expected values. It latches a pass, fail or timeout verdict and drives the green/red indicators. It also records which step failed and the offending value for debug.

## Interface
- WIDTH, 32: result bus width.
- DEPTH, 1: number of expected results in the sequence; at least 1.
- IDX_BITS, 1: index width; 2^IDX_BITS ≥ DEPTH.
- EXPECTED, 32'h00004038: flat DEPTH*WIDTH vector; step i expects bits [i*WIDTH +: WIDTH].
- MASK, all ones (WIDTH bits): only bits set in MASK are compared.
- TO_BITS, 24: timeout counter width.
- TIMEOUT, 0: maximum idle cycles between triggers. 0 disables the timeout.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- restart  in  1  synchronous re-arm of the checker without a global reset.
- temp_out  in  WIDTH  CPU result value.
- temp_trg  in  1  result-valid strobe, one cycle per result.
- busy  out  1  checker is running.
- done  out  1  verdict has been reached.
- led_g  out  1  pass.
- led_r  out  1  fail or timeout.
- timeout  out  1  the failure was caused by the timeout.
- step  out  IDX_BITS  index of the next expected step; frozen at the verdict.
- fail_val  out  WIDTH  temp_out value that was sampled at the mismatch.

## Operation
- States:
  - RUN: entered at reset and on restart.
  - PASS: terminal.
  - FAIL: terminal.
- RUN, temp_trg=1:
  - Compare (temp_out & MASK) with (EXPECTED[step] & MASK).
  - Match, step < DEPTH-1: increment step, clear the timeout counter.
  - Match, step == DEPTH-1: go to PASS; step holds DEPTH-1.
  - Mismatch: go to FAIL, fail_val <= temp_out, timeout=0; step holds the failing index.
- RUN, temp_trg=0, TIMEOUT≠0:
  - The timeout counter increments every cycle.
  - When the counter equals TIMEOUT-1, go to FAIL with timeout=1 and fail_val=0.
- The timeout counter is TO_BITS wide. It saturates and never wraps; TIMEOUT must fit in TO_BITS.
- PASS/FAIL: temp_trg is ignored and the timeout counter is frozen. Only restart or rst leaves these states.
- Outputs are registered and decoded from the state:
  - busy = RUN.
  - done = PASS|FAIL.
  - led_g = PASS.
  - led_r = FAIL.
- With DEPTH=1, TIMEOUT=0 and MASK all ones, the block behaves as the existing single-value pass/fail indicator, except that the verdict latches.

## Timing
- Reset values, and values after restart: state RUN, busy=1, done=0, led_g=0, led_r=0, timeout=0, step=0, fail_val=0, timeout counter=0.
- Latency: a trigger at edge N is reflected in step, led_g/led_r, done and fail_val after edge N, i.e. valid in cycle N+1.
- Back-to-back triggers on consecutive cycles are each accepted; there are no bubbles.
- A trigger in the same cycle the counter reaches TIMEOUT-1: the trigger wins and is compared normally. The counter is cleared on a match.
- restart and temp_trg in the same cycle: restart wins and the trigger is dropped.
- rst overrides everything, including restart, in any state and mid-sequence.
- Timeout: with no triggers after re-arm, FAIL is visible exactly TIMEOUT cycles after the arming edge.

## Test plan
- Legacy default parameters: reset, then temp_trg with temp_out=32'h00004038 -> next cycle led_g=1, led_r=0, done=1. Then a trigger with 32'h0 -> no change.
- DEPTH=3, EXPECTED={32'h3,32'h2,32'h1}: triggers 1, 2, 3 on consecutive cycles -> step goes 1, 2 and then PASS one cycle after the third trigger; step=2.
- Same parameters: triggers 1, then 7 -> FAIL, led_r=1, step=1, fail_val=32'h7, timeout=0. A further trigger with 2 is ignored.
- TIMEOUT=5: reset with no triggers -> FAIL with timeout=1 visible 5 cycles after reset deasserts. With a trigger of the correct value in the cycle the counter reaches 4 -> no timeout, and step advances.
- MASK=32'h0000FFFF, EXPECTED=32'h00004038: trigger with 32'hABCD4038 -> PASS.
- After FAIL, assert restart for one cycle alongside a trigger -> next cycle busy=1, step=0, led_r=0, fail_val=0, and the trigger is not counted. Asserting rst mid-sequence at step=1 -> step=0.
